tl_sink_allocator: RTL

- Manager-side sink-ID allocator for TileLink-C: shares a pool of 2**SinkWidth D-channel sink IDs among NumReq Grant/GrantData generators, then recycles each ID when its GrantAck arrives on channel E.
- Sits between the manager's grant sources and its D mux, upstream of any sink-width adapters.
- Guarantees no two outstanding Grants share a sink ID.

---
 rtl/tl_sink_allocator_if.sv | 26 ++
 rtl/tl_sink_allocator.sv | 104 ++++++++++
 2 files changed

// File: rtl/tl_sink_allocator_if.sv
// Handshake bundle between the grant generators, the E-channel release path
// and the sink-ID allocator.
interface tl_sink_allocator_if #(
  parameter int SinkWidth = 2,
  parameter int NumReq    = 4
);
  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [SinkWidth-1:0]       alloc_sink_o;
  logic                       e_valid_i;
  logic                       e_ready_o;
  logic [SinkWidth-1:0]       e_sink_i;
  logic [(2**SinkWidth)-1:0]  busy_o;
  logic [SinkWidth:0]         free_cnt_o;
  logic                       err_o;

  modport master (
    output req_valid_i, e_valid_i, e_sink_i,
    input  req_ready_o, alloc_sink_o, e_ready_o, busy_o, free_cnt_o, err_o
  );

  modport slave (
    input  req_valid_i, e_valid_i, e_sink_i,
    output req_ready_o, alloc_sink_o, e_ready_o, busy_o, free_cnt_o, err_o
  );
endinterface

// File: rtl/tl_sink_allocator.sv
// Shares a pool of D-channel sink IDs among Grant generators with round-robin
// arbitration and recycles each ID when its GrantAck arrives on channel E.
module tl_sink_allocator #(
  parameter int SinkWidth = 2,
  parameter int NumReq    = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  tl_sink_allocator_if.slave sink_if
);
  localparam int NumSinks = 1 << SinkWidth;
  localparam int RrW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [SinkWidth:0] NumSinksW = (SinkWidth+1)'(NumSinks);

  logic [NumSinks-1:0]  busy_q, busy_d;
  logic [SinkWidth:0]   free_cnt_q, free_cnt_d;
  logic [RrW-1:0]       rr_q, rr_d;
  logic                 err_q, err_d;

  logic [SinkWidth-1:0] alloc_sink;
  logic                 any_free;
  logic [NumReq-1:0]    grant;
  logic                 found;
  int                   win;
  int                   idx;
  logic                 alloc_fire;
  logic                 rel_ok;
  logic                 rel_bad;
  logic [SinkWidth:0]   used_cnt;

  // Lowest free ID; allocation looks only at registered state, so an ID being
  // released this cycle is never offered until the next one.
  always_comb begin
    alloc_sink = '0;
    for (int i = NumSinks - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_sink = SinkWidth'(i);
    end
    any_free = ~&busy_q;
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int off = 0; off < NumReq; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && sink_if.req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && any_free && rst_ni) grant[win] = 1'b1;
  end

  always_comb begin
    alloc_fire = |grant;
    rel_ok     = rst_ni && sink_if.e_valid_i && busy_q[sink_if.e_sink_i];
    rel_bad    = rst_ni && sink_if.e_valid_i && !busy_q[sink_if.e_sink_i];

    busy_d = busy_q;
    if (rel_ok)     busy_d[sink_if.e_sink_i] = 1'b0;
    if (alloc_fire) busy_d[alloc_sink]       = 1'b1;

    free_cnt_d = free_cnt_q + (SinkWidth+1)'(rel_ok) - (SinkWidth+1)'(alloc_fire);

    rr_d = rr_q;
    if (alloc_fire) rr_d = (win == NumReq - 1) ? '0 : RrW'(win + 1);

    err_d = err_q | rel_bad;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      free_cnt_q <= NumSinksW;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
      rr_q       <= rr_d;
      err_q      <= err_d;
    end
  end

  assign sink_if.req_ready_o  = grant;
  assign sink_if.alloc_sink_o = alloc_sink;
  assign sink_if.e_ready_o    = rst_ni;
  assign sink_if.busy_o       = busy_q;
  assign sink_if.free_cnt_o   = free_cnt_q;
  assign sink_if.err_o        = err_q;

  // The incremental counter must always agree with the bitmap population.
  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < NumSinks; i++) used_cnt = used_cnt + (SinkWidth+1)'(busy_q[i]);
  end

  free_cnt_matches_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    free_cnt_q == NumSinksW - used_cnt);

endmodule
